// File: rtl/f1_start_sequencer_if.sv
// Start-light sequencer control and status bundle.
// Driver buttons in, lamp drive and reaction result out.
interface f1_start_sequencer_if #(
  parameter int N_LIGHTS = 10,
  parameter int RT_W     = 16
);
  logic                trigger;
  logic                abort;
  logic                react;
  logic                dir;
  logic [N_LIGHTS-1:0] ledr;
  logic                busy;
  logic                lights_out;
  logic                result_valid;
  logic [RT_W-1:0]     reaction_time;
  logic                jump_start;

  modport master (
    output trigger, abort, react, dir,
    input  ledr, busy, lights_out,
    input  result_valid, reaction_time,
    input  jump_start
  );

  modport slave (
    input  trigger, abort, react, dir,
    output ledr, busy, lights_out,
    output result_valid, reaction_time,
    output jump_start
  );
endinterface

// File: rtl/f1_start_sequencer.sv
// F1 start-light sequencer: lamp fill, random hold,
// reaction timing and jump-start detection.
module f1_start_sequencer #(
  parameter int N_LIGHTS    = 10,
  parameter int STEP_CYCLES = 25_000_000,
  parameter int HOLD_MIN    = 1,
  parameter int HOLD_BITS   = 2,
  parameter int RT_W        = 16
) (
  input logic                  sysclk,
  input logic                  reset,
  f1_start_sequencer_if.slave  bus
);

  localparam int SW = $clog2(STEP_CYCLES);
  localparam int LW = $clog2(N_LIGHTS + 1);

  typedef enum logic [2:0] {
    IDLE, COUNT, HOLD, TIMING, FAULT
  } state_t;

  state_t              state;
  state_t              nxt;
  logic [15:0]         lfsr;
  logic [SW-1:0]       step_cnt;
  logic [LW-1:0]       lit;
  logic [8:0]          hold_rem;
  logic [RT_W-1:0]     rt_cnt;
  logic                dir_q;
  logic [N_LIGHTS-1:0] ledr;
  logic                busy;
  logic                lights_out;
  logic                result_valid;
  logic [RT_W-1:0]     reaction_time;
  logic                jump_start;
  logic                step;
  logic                lfsr_fb;

  assign step    = step_cnt == SW'(STEP_CYCLES - 1);
  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:
        if (bus.trigger && !bus.react)
          nxt = COUNT;
      COUNT:
        if (bus.react)
          nxt = FAULT;
        else if (step && lit == LW'(N_LIGHTS - 1))
          nxt = HOLD;
      HOLD:
        if (bus.react)
          nxt = FAULT;
        else if (step && hold_rem == 9'd1)
          nxt = TIMING;
      TIMING:
        if (bus.react)
          nxt = IDLE;
      FAULT: nxt = FAULT;
      default: nxt = IDLE;
    endcase
    if (bus.abort)
      nxt = IDLE;
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state         <= IDLE;
      lfsr          <= 16'hACE1;
      step_cnt      <= '0;
      lit           <= '0;
      hold_rem      <= '0;
      rt_cnt        <= '0;
      dir_q         <= 1'b0;
      ledr          <= '0;
      busy          <= 1'b0;
      lights_out    <= 1'b0;
      result_valid  <= 1'b0;
      reaction_time <= '0;
      jump_start    <= 1'b0;
    end else begin
      state        <= nxt;
      busy         <= nxt != IDLE;
      lights_out   <= state == HOLD && nxt == TIMING;
      result_valid <= 1'b0;

      // Randomness comes from how long the rig sat idle
      if (state == IDLE)
        lfsr <= {lfsr_fb, lfsr[15:1]};

      if (nxt != state)
        step_cnt <= '0;
      else if (state == COUNT || state == HOLD
               || state == FAULT)
        step_cnt <= step ? '0 : step_cnt + 1'b1;

      if (state == IDLE && nxt == COUNT) begin
        dir_q      <= bus.dir;
        lit        <= '0;
        jump_start <= 1'b0;
      end

      if (nxt == IDLE)
        ledr <= '0;
      else if (nxt == FAULT && state != FAULT) begin
        ledr       <= '1;
        jump_start <= 1'b1;
      end else if (state == FAULT && step)
        ledr <= ~ledr;
      else if (state == COUNT && step) begin
        lit  <= lit + 1'b1;
        ledr <= dir_q ? {ledr[N_LIGHTS-2:0], 1'b1}
                      : {1'b1, ledr[N_LIGHTS-1:1]};
      end else if (state == HOLD && nxt == TIMING)
        ledr <= '0;

      if (state == COUNT && nxt == HOLD)
        hold_rem <= 9'(HOLD_MIN)
                  + 9'(lfsr[HOLD_BITS-1:0]);
      else if (state == HOLD && nxt == HOLD && step)
        hold_rem <= hold_rem - 9'd1;

      if (state == HOLD && nxt == TIMING)
        rt_cnt <= '0;
      else if (state == TIMING && rt_cnt != '1)
        rt_cnt <= rt_cnt + 1'b1;

      if (state == TIMING && nxt == IDLE
          && !bus.abort) begin
        reaction_time <= rt_cnt;
        result_valid  <= 1'b1;
      end
    end
  end

  assign bus.ledr          = ledr;
  assign bus.busy          = busy;
  assign bus.lights_out    = lights_out;
  assign bus.result_valid  = result_valid;
  assign bus.reaction_time = reaction_time;
  assign bus.jump_start    = jump_start;

endmodule
